// File: rtl/argmax_classifier.sv
// Argmax stage: captures the dense-layer score vector on a rising in_valid edge
// and scans it one element per cycle with one signed comparator.
module argmax_classifier #(
  parameter int CLASS_NB = 10,
  parameter int WIDTH    = 16,
  parameter int IDX_W    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic signed [WIDTH-1:0] in_data [0:CLASS_NB-1],
  input  logic                    in_valid,
  output logic [IDX_W-1:0]        class_out,
  output logic signed [WIDTH-1:0] max_out,
  output logic                    class_done,
  output logic                    class_valid,
  output logic                    busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CLASS_NB - 1);

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic signed [WIDTH-1:0] r_buf [0:CLASS_NB-1];
  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W-1:0]        r_best_idx;
  logic signed [WIDTH-1:0] r_best_val;
  logic                    r_in_valid_q;
  logic [IDX_W-1:0]        r_class_out;
  logic signed [WIDTH-1:0] r_max_out;
  logic                    r_class_done;
  logic                    r_class_valid;

  logic                    w_start;
  logic                    w_capture;
  logic                    w_take;
  logic                    w_finish;
  logic [IDX_W-1:0]        w_cand_idx;
  logic signed [WIDTH-1:0] w_cand_val;

  // Rising edge only, so a level that stays high starts a single scan.
  assign w_start = enable && in_valid && !r_in_valid_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = S_SCAN;
      S_SCAN: if (!enable || (r_idx == LAST_IDX)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath control
  always_comb begin
    busy       = (r_state == S_SCAN);
    w_capture  = (r_state == S_IDLE) && w_start;
    w_take     = 1'b0;
    w_finish   = 1'b0;
    w_cand_idx = r_best_idx;
    w_cand_val = r_best_val;
    if (r_state == S_SCAN && enable) begin
      // Strictly greater keeps the lowest index on ties.
      w_take   = (r_buf[r_idx] > r_best_val);
      w_finish = (r_idx == LAST_IDX);
      if (w_take) begin
        w_cand_idx = r_idx;
        w_cand_val = r_buf[r_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_in_valid_q <= 1'b0;
    else       r_in_valid_q <= in_valid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CLASS_NB; i++) r_buf[i] <= '0;
      r_idx      <= '0;
      r_best_idx <= '0;
      r_best_val <= '0;
    end else if (w_capture) begin
      for (int i = 0; i < CLASS_NB; i++) r_buf[i] <= in_data[i];
      r_idx      <= IDX_W'(1);
      r_best_idx <= '0;
      r_best_val <= in_data[0];
    end else if (r_state == S_SCAN && enable) begin
      r_best_idx <= w_cand_idx;
      r_best_val <= w_cand_val;
      if (!w_finish) r_idx <= r_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_class_out   <= '0;
      r_max_out     <= '0;
      r_class_done  <= 1'b0;
      r_class_valid <= 1'b0;
    end else begin
      r_class_done <= w_finish;
      if (w_capture) r_class_valid <= 1'b0;
      if (w_finish) begin
        r_class_out   <= w_cand_idx;
        r_max_out     <= w_cand_val;
        r_class_valid <= 1'b1;
      end
    end
  end

  assign class_out   = r_class_out;
  assign max_out     = r_max_out;
  assign class_done  = r_class_done;
  assign class_valid = r_class_valid;

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed bench for argmax_classifier: vector table plus hand-written
// sequences for level handling, buffer isolation, abort and mid-scan reset.
module tb_argmax_classifier;
  localparam int N  = 10;
  localparam int W  = 16;
  localparam int IW = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                enable;
  logic                in_valid;
  logic signed [W-1:0] in_data [0:N-1];
  logic [IW-1:0]       class_out;
  logic signed [W-1:0] max_out;
  logic                class_done;
  logic                class_valid;
  logic                busy;

  argmax_classifier #(.CLASS_NB(N), .WIDTH(W), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_data(in_data),
    .in_valid(in_valid), .class_out(class_out), .max_out(max_out),
    .class_done(class_done), .class_valid(class_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0][W-1:0] s;
    logic [IW-1:0]       cls;
    logic [W-1:0]        mx;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs [6];
  vec_t va, vb;

  function automatic vec_t mk(int a0, int a1, int a2, int a3, int a4, int a5,
                              int a6, int a7, int a8, int a9, int c, int m);
    vec_t v;
    v.s[0] = W'(a0); v.s[1] = W'(a1); v.s[2] = W'(a2); v.s[3] = W'(a3);
    v.s[4] = W'(a4); v.s[5] = W'(a5); v.s[6] = W'(a6); v.s[7] = W'(a7);
    v.s[8] = W'(a8); v.s[9] = W'(a9);
    v.cls = IW'(c);
    v.mx  = W'(m);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    for (int i = 0; i < N; i++) in_data[i] = v.s[i];
  endtask

  // Called at the negedge just after the capture edge with c0 edges elapsed.
  task automatic wait_done(input int c0, output int cyc, output int bcnt);
    cyc  = c0;
    bcnt = 0;
    while (class_done !== 1'b1 && cyc < 20) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_result(input string nm, input vec_t v, input int cyc);
    chk({nm, "_latency"}, W'(cyc), W'(9));
    chk({nm, "_class"}, W'(class_out), W'(v.cls));
    chk({nm, "_max"}, max_out, v.mx);
    chk({nm, "_valid"}, W'(class_valid), W'(1));
    @(negedge clk);
    chk({nm, "_done_pulse"}, W'(class_done), W'(0));
    chk({nm, "_valid_hold"}, W'(class_valid), W'(1));
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int cyc, bcnt;
    @(negedge clk);
    drive(v);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(0, cyc, bcnt);
    chk({nm, "_busy_cycles"}, W'(bcnt), W'(9));
    check_result(nm, v, cyc);
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (class_done === 1'b1) cnt++;
    end
  endtask

  initial begin
    int cyc, bcnt, cnt;
    vecs[0] = mk(3, 10, 7, 0, 2, 1, 40, 5, 9, 8, 6, 40);
    vecs[1] = mk(25, 0, 0, 0, 0, 0, 0, 0, 0, 25, 0, 25);
    vecs[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 99, 9, 99);
    vecs[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[4] = mk(1, 50, 3, 50, 2, 49, 0, 7, 50, 4, 1, 50);
    vecs[5] = mk(-5, -3, -8, -32768, -1, -2, -9, -7, -6, -4, 4, -1);
    va = mk(11, 12, 13, 14, 77, 15, 16, 17, 18, 19, 4, 77);
    vb = mk(500, 1, 1, 1, 1, 1, 1, 1, 1, 600, 9, 600);

    enable   = 1'b1;
    in_valid = 1'b0;
    reset    = 1'b0;
    drive(vecs[3]);
    #2 reset = 1'b1;
    #1;
    chk("rst_class", W'(class_out), W'(0));
    chk("rst_max", max_out, W'(0));
    chk("rst_done", W'(class_done), W'(0));
    chk("rst_valid", W'(class_valid), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", W'(busy), W'(0));
    chk("idle_valid", W'(class_valid), W'(0));
    chk("idle_class", W'(class_out), W'(0));

    for (int k = 0; k < 6; k++) run_vec($sformatf("vec%0d", k), vecs[k]);

    // Level held high for 30 cycles starts exactly one scan.
    @(negedge clk);
    drive(vecs[0]);
    in_valid = 1'b1;
    count_done(30, cnt);
    in_valid = 1'b0;
    chk("level_done_count", W'(cnt), W'(1));
    chk("level_class", W'(class_out), W'(6));
    chk("level_max", max_out, W'(40));
    count_done(5, cnt);
    chk("level_no_retrigger", W'(cnt), W'(0));

    // Input changes after capture do not reach the result.
    @(negedge clk);
    drive(va);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    drive(vb);
    wait_done(0, cyc, bcnt);
    check_result("isolate", va, cyc);

    // A second rising edge mid-scan is ignored.
    @(negedge clk);
    drive(vecs[5]);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    drive(vb);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(3, cyc, bcnt);
    check_result("second_edge", vecs[5], cyc);
    count_done(15, cnt);
    chk("second_edge_no_rerun", W'(cnt), W'(0));

    // Drop enable at SCAN cycle 4: abort, keep old result (class 4, -1).
    @(negedge clk);
    drive(va);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_valid", W'(class_valid), W'(0));
    chk("abort_class", W'(class_out), W'(4));
    chk("abort_max", max_out, 16'hFFFF);
    count_done(12, cnt);
    chk("abort_no_done", W'(cnt), W'(0));
    chk("abort_class_hold", W'(class_out), W'(4));
    enable = 1'b1;

    // Reset at SCAN cycle 5, then a clean run.
    @(negedge clk);
    drive(vecs[0]);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", W'(busy), W'(0));
    chk("midrst_class", W'(class_out), W'(0));
    chk("midrst_max", max_out, W'(0));
    chk("midrst_valid", W'(class_valid), W'(0));
    @(negedge clk);
    reset = 1'b0;
    count_done(12, cnt);
    chk("midrst_no_done", W'(cnt), W'(0));
    chk("midrst_busy_after", W'(busy), W'(0));
    run_vec("after_rst", vecs[4]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/argmax_classifier.md
Name: argmax_classifier

Overview:
- Final classification stage; sits directly downstream of the output dense layer (10 ReLU-activated 16-bit scores).
- On the dense layer's done strobe, captures the score vector and scans it sequentially, one element per cycle, with a single comparator.
- Produces the winning class index (digit 0-9) and its score, with a done pulse and a held valid flag for the top-level/display logic.

Parameters:
- CLASS_NB, 10, number of scores/classes; legal range 2..16.
- WIDTH, 16, score width, signed two's complement.
- IDX_W, 4, index width; must satisfy 2**IDX_W >= CLASS_NB.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  stage enable; low aborts any scan and blocks new captures.
- in_data  input  signed [WIDTH-1:0] x [0:CLASS_NB-1]  score vector from the output dense layer.
- in_valid  input  1  connected to the dense layer's layer_done; level signal, may stay high.
- class_out  output  [IDX_W-1:0]  index of the maximum score.
- max_out  output  signed [WIDTH-1:0]  value of the maximum score.
- class_done  output  1  one-cycle pulse when a new result is written.
- class_valid  output  1  high while class_out/max_out hold a result for the current vector.
- busy  output  1  high in SCAN.

Behaviour:
- Reset (async, immediate): state=IDLE; class_out=0, max_out=0, class_done=0, class_valid=0, busy=0; capture buffer, scan counter, best regs and in_valid edge register cleared.
- Start condition: enable && in_valid && !in_valid_q, where in_valid_q is in_valid registered every cycle (also while busy/disabled). The condition is a rising edge only; a held-high in_valid starts exactly one scan.
- States: IDLE, SCAN.
- IDLE:
  - On start: latch in_data into buffer; best_val=in_data[0], best_idx=0, idx=1.
  - Clear class_valid; busy=1 next cycle; go to SCAN.
- SCAN, each cycle:
  - If buf[idx] > best_val (signed, strictly greater): best_val=buf[idx], best_idx=idx.
  - If idx==CLASS_NB-1: class_out and max_out take the final best (including this cycle's compare); class_done=1 for one cycle; class_valid=1; busy=0; go to IDLE.
  - Otherwise idx=idx+1.
- Ties: the lowest index wins.
- Latency: with the capture on edge E, the results, class_done and class_valid appear after edge E+(CLASS_NB-1). That is 9 cycles for the default, with SCAN occupied for 9 cycles.
- Buffer isolation: in_data changes after the capture edge do not affect the result.
- A start edge during SCAN is ignored; no queuing. in_valid_q still updates, so a level that stays high does not retrigger afterwards.
- enable low in SCAN: abort to IDLE on the next edge. busy=0, class_valid stays 0, no class_done, and class_out/max_out keep their old values.
- enable low in IDLE: no capture; outputs held.
- class_valid stays high until the next capture or reset.
- Reset asserted mid-scan: everything returns to reset values immediately; no pulse when reset is released.
- Widths: comparison on full WIDTH signed. Inputs are ReLU outputs (≥0) but negative values must compare correctly. No arithmetic growth.

Test Plan:
- Reset/idle: assert reset mid-cycle -> all outputs 0 immediately; release with in_valid=0 -> outputs stay 0, busy=0.
- Basic argmax: scores {3,10,7,0,2,1,40,5,9,8}, pulse in_valid -> busy for 9 cycles, then class_out=6, max_out=40, class_done one cycle, class_valid held high.
- Ties and ends:
  - {25,0,…,0,25} -> class_out=0, max_out=25.
  - {0,…,0,99 at idx 9} -> class_out=9, max_out=99.
  - All zeros -> class_out=0, max_out=0.
- Signed compare: {-5,-3,-8,-32768,-1,-2,-9,-7,-6,-4} -> class_out=4, max_out=-1.
- Level/buffer handling:
  - Hold in_valid high for 30 cycles -> exactly one class_done.
  - Change in_data one cycle after capture -> result reflects the captured vector.
  - Second rising edge during SCAN -> ignored.
- Abort/reset mid-scan:
  - Drop enable at SCAN cycle 4 -> no class_done, class_valid=0, old class_out/max_out retained.
  - Assert reset at SCAN cycle 5 -> immediate reset values; a new in_valid edge afterwards completes normally in 9 cycles.
